audio_sample_fetch: RTL
=======================

# audio_sample_fetch

Upstream feeder for the I2S transmitter. Tracks playback position from the transmitter's LRCLK frame boundaries and fetches 16-bit words from sample memory through a request/acknowledge port. Double-buffers those words and presents the current 8-bit sample, registered, on the `sample` input of the I2S block. The I2S block's own `addr` output is left unconnected; this block owns the playback pointer.

## Interface
- `ADDR_W`, default 24: byte-address width of the sample space. Memory word address is `ADDR_W-1` bits.
- `Clk`  in  1: system clock; all logic is on its rising edge.
- `Reset_n`  in  1: asynchronous, active-low reset.
- `lrclk`  in  1: I2S frame clock. Asynchronous to `Clk`; synchronized internally.
- `play`  in  1: level. Low holds the pointer at 0 and flushes the buffers. Sampled synchronously.
- `loop`  in  1: at end of data, 1 = wrap to 0, 0 = stop.
- `end_addr`  in  ADDR_W: byte count of the clip. The last byte played is `end_addr-1`. Must be stable while `play` is high.
- `mem_rd`  out  1: read request. Held high until `mem_ack`.
- `mem_addr`  out  ADDR_W-1: word address. Stable while `mem_rd` is high.
- `mem_rdata`  in  16: read data. Valid in the cycle `mem_ack` is high.
- `mem_ack`  in  1: single-cycle completion pulse.
- `sample`  out  8: current sample, to I2S `sample`.
- `done`  out  1: end reached with `loop` = 0.
- `underrun`  out  1: sticky flag. A frame boundary occurred while the needed word was not buffered.

## Operation
- **Frame detect:** `lrclk` passes through three flops (s1, s2, s3). `fall` = s3 & ~s2.
- **Pointer `ptr`:**
  - `play` = 0: `ptr` is 0.
  - On `fall` with `play` = 1 and `done` = 0: `ptr` <= `ptr`+1.
  - If `ptr`+1 == `end_addr`: `loop` = 1 sets `ptr` <= 0; `loop` = 0 holds `ptr` and sets `done`.
  - `end_addr` == 0 with `play` = 1: `done` sets on the next cycle; no fetches are issued.
- **Byte select:** `ptr[0]` = 0 selects `cur_word[7:0]`; `ptr[0]` = 1 selects `cur_word[15:8]`.
- **Buffers:**
  - `cur_word` holds word `ptr[ADDR_W-1:1]`. `nxt_word` holds word `ptr[ADDR_W-1:1]`+1.
  - Each buffer has its own valid bit.
- **Pointer move to the next word** (`ptr[0]` 1→0, no wrap): `cur` <= `nxt` (data and valid); `nxt_valid` <= 0.
- **Buffer flush:** `play` low, a wrap, or `done` clears both valid bits.
- **Fetch FSM:**
  - IDLE:
    - If `play` = 1, `done` = 0 and `cur` is invalid: request the cur word.
    - Else if `nxt` is invalid and the nxt word is below `(end_addr+1)>>1`: request the nxt word.
    - When requesting, latch the tag (word address) into `mem_addr` and go to REQ.
  - REQ: `mem_rd` = 1. On `mem_ack`, go to IDLE and write `mem_rdata`:
    - into `cur` if the tag equals the current cur word address;
    - else into `nxt` if the tag equals the current nxt word address;
    - else discard.
  - An in-flight request is never aborted, including after flush or `play` drop. Its tag check discards stale data.
  - An ack landing in the same cycle as a buffer swap is checked against the post-swap addresses.
- **`sample` register:**
  - 0 when `play` = 0, `done` = 1, or `cur` is invalid.
  - Otherwise the selected byte.
- **`underrun`:** set on `fall` (with `play` = 1, `done` = 0) when the word needed after the increment is invalid. Cleared when `play` = 0.

## Timing
- Reset values: `mem_rd` = 0, `mem_addr` = 0, `sample` = 0, `done` = 0, `underrun` = 0, `ptr` = 0, both valid bits 0, FSM in IDLE, s1–s3 = 1.
- An `lrclk` fall before Clk edge k is captured in s1 at k, making `fall` high in the cycle after k+1.
- `ptr` updates at edge k+2. `sample` reflects the new `ptr` at edge k+3.
- Fetch latency: `mem_rd` rises the edge after the IDLE decision. Data is usable in `sample` the edge after `mem_ack`.
- Back-to-back requests need one IDLE cycle between them.
- Frame period is ≥ 64 sclk, far longer than the swap path. No underrun occurs while memory latency is below one frame.

## Test plan
1. **Reset mid-request:** assert `Reset_n` low while `mem_rd` = 1 → all outputs are 0 immediately; after release, the FSM re-requests word 0.
2. **Start from play:** memory words 0x2211, 0x4433; raise `play`; ack each request after 3 cycles → `mem_addr` 0 then 1; `sample` = 0x11; after `lrclk` falls: 0x22, 0x33, 0x44; `underrun` = 0.
3. **Wrap with `loop`:** `end_addr` = 3, `loop` = 1 → `sample` sequence 0x11, 0x22, 0x33, 0x11; a refetch of word 0 is observed.
4. **Stop without `loop`:** `end_addr` = 3, `loop` = 0 → `done` = 1 after the third frame; `sample` = 0; no further `mem_rd`.
5. **Slow memory:** delay `mem_ack` longer than 2 frames → `underrun` = 1 and `sample` = 0 until the word arrives. Dropping `play` clears `underrun`.
6. **Stale ack:** drop `play` during REQ for word 1 → the ack is discarded; restart fetches word 0 and `sample` = 0x11, not 0x33.

Source files
------------

// File: rtl/audio_sample_fetch.sv
// Sample fetcher feeding the I2S transmitter: tracks the playback byte
// pointer from LRCLK frames and double-buffers 16-bit words from memory.
module audio_sample_fetch #(
  parameter int ADDR_W = 24
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              lrclk,
  input  logic              play,
  input  logic              loop,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              mem_rd,
  output logic [ADDR_W-2:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [7:0]        sample,
  output logic              done,
  output logic              underrun
);

  localparam int WA = ADDR_W - 1;

  typedef enum logic {IDLE, REQ} state_t;

  state_t state;

  logic s1, s2, s3;
  logic fall;
  logic run;
  logic end0;
  logic inc;
  logic miss;
  logic ack;

  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_n;
  logic [ADDR_W-1:0] ptr_inc;
  logic              done_n;
  logic              wrap;
  logic              swap;
  logic              flush;

  logic [WA-1:0]   cur_a;
  logic [WA-1:0]   nxt_a;
  logic [WA-1:0]   cur_an;
  logic [WA-1:0]   nxt_an;
  logic [ADDR_W:0] lim_w;
  logic            nxt_ok;

  logic [15:0] cur_word;
  logic [15:0] nxt_word;
  logic        cur_v;
  logic        nxt_v;

  assign fall    = s3 & ~s2;
  assign run     = play & ~done;
  assign end0    = (end_addr == '0);
  assign ptr_inc = ptr + ADDR_W'(1);
  assign ack     = (state == REQ) & mem_ack;

  assign cur_a  = ptr[ADDR_W-1:1];
  assign nxt_a  = cur_a + WA'(1);
  assign lim_w  = ({1'b0, end_addr} + (ADDR_W+1)'(1)) >> 1;
  assign nxt_ok = ({2'b00, nxt_a} < lim_w);

  // Plain increments only; wrap and stop flush the buffers by design
  assign inc  = run & ~end0 & fall & (ptr_inc != end_addr);
  assign miss = ptr[0] ? ~nxt_v : ~cur_v;

  always_comb begin
    ptr_n  = ptr;
    done_n = done;
    wrap   = 1'b0;
    swap   = 1'b0;
    if (!play) begin
      ptr_n  = '0;
      done_n = 1'b0;
    end else if (!done) begin
      if (end0) begin
        done_n = 1'b1;
      end else if (fall) begin
        if (ptr_inc == end_addr) begin
          if (loop) begin
            ptr_n = '0;
            wrap  = 1'b1;
          end else begin
            done_n = 1'b1;
          end
        end else begin
          ptr_n = ptr_inc;
          swap  = ptr[0];
        end
      end
    end
    flush  = ~play | wrap | done_n;
    cur_an = ptr_n[ADDR_W-1:1];
    nxt_an = cur_an + WA'(1);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= lrclk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr      <= '0;
      done     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      ptr  <= ptr_n;
      done <= done_n;
      if (!play)
        underrun <= 1'b0;
      else if (inc && miss)
        underrun <= 1'b1;
    end
  end

  // Acks are matched against post-swap addresses; flush discards them
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cur_word <= '0;
      nxt_word <= '0;
      cur_v    <= 1'b0;
      nxt_v    <= 1'b0;
    end else if (flush) begin
      cur_v <= 1'b0;
      nxt_v <= 1'b0;
    end else begin
      if (swap) begin
        cur_word <= nxt_word;
        cur_v    <= nxt_v;
        nxt_v    <= 1'b0;
      end
      if (ack) begin
        if (mem_addr == cur_an) begin
          cur_word <= mem_rdata;
          cur_v    <= 1'b1;
        end else if (mem_addr == nxt_an) begin
          nxt_word <= mem_rdata;
          nxt_v    <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (run && !end0 && !cur_v) begin
            mem_addr <= cur_a;
            mem_rd   <= 1'b1;
            state    <= REQ;
          end else if (run && !nxt_v && nxt_ok) begin
            mem_addr <= nxt_a;
            mem_rd   <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_rd <= 1'b0;
            state  <= IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      sample <= '0;
    else if (!play || done || !cur_v)
      sample <= '0;
    else
      sample <= ptr[0] ? cur_word[15:8] : cur_word[7:0];
  end

endmodule
